// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction
// fetch (requester 0) and data load/store (requester 1). Each access runs
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle Ack), so a request
// sampled at cycle t is acknowledged at t+MEM_LAT+1.
// o_sel steers the external address/write-data muxes toward the current owner.
// Optional build macro ARB_FIXED_PRIO_EN: requester 1 always wins ties.
// Without it, ties are broken round-robin against the last-granted requester.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no access in flight; arbitrate between pending requests
// S_ACCESS | memory access in progress; address/data/sel held stable
// S_RESP   | Ack pulse to the owner; Rdata valid for reads

module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2     // 1..15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic [DATA_W-1:0] i_addr0,
  input  logic              i_we0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_addr1,
  input  logic              i_we1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_sel,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_sel;
  logic              r_we;
  logic              r_mem_we;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [DATA_W-1:0] r_rdata;
  logic              w_grant;
  logic              w_winner;
`ifndef ARB_FIXED_PRIO_EN
  logic              r_last;
`endif

  // Arbitration: pick the winner among the requests presented in IDLE.
  always_comb begin
    w_grant = i_req0 | i_req1;
`ifdef ARB_FIXED_PRIO_EN
    w_winner = i_req1;
`else
    if (i_req0 && i_req1) w_winner = ~r_last;
    else                  w_winner = i_req1;
`endif
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the winner's access, run the latency counter, capture read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cnt      <= 4'd0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last     <= 1'b1;
`endif
    end else begin
      // The write strobe only ever lasts for the first ACCESS cycle.
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel      <= w_winner;
`ifndef ARB_FIXED_PRIO_EN
            r_last     <= w_winner;
`endif
            r_mem_addr <= w_winner ? i_addr1  : i_addr0;
            r_mem_din  <= w_winner ? i_wdata1 : i_wdata0;
            r_we       <= w_winner ? i_we1    : i_we0;
            r_mem_we   <= w_winner ? i_we1    : i_we0;
            r_cnt      <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else if (!r_we)    r_rdata <= i_mem_dout;
        end
        default: ;
      endcase
    end
  end

  assign o_ack0     = (r_state == S_RESP) && !r_sel;
  assign o_ack1     = (r_state == S_RESP) &&  r_sel;
  assign o_busy     = (r_state != S_IDLE);
  assign o_sel      = r_sel;
  assign o_rdata    = r_rdata;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_we   = r_mem_we;
  assign o_mem_din  = r_mem_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with MEM_LAT=2.
// Memory model: two preloaded read words plus one writable word.
module tb_mem_port_arbiter;

  localparam int DW = 32;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [DW-1:0] addr0, wdata0, addr1, wdata1;
  logic          ack0, ack1, sel, busy, mem_we;
  logic [DW-1:0] rdata, mem_addr, mem_din, mem_dout;

  int n_checks = 0;
  int n_fails  = 0;

  mem_port_arbiter #(.DATA_W(DW), .MEM_LAT(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .i_we0(we0), .i_wdata0(wdata0),
    .i_req1(req1), .i_addr1(addr1), .i_we1(we1), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_sel(sel), .o_busy(busy),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // memory model
  logic [DW-1:0] m_wr_addr = 32'hFFFF_FFFF;
  logic [DW-1:0] m_wr_data = 32'h0;
  always @(posedge clk) begin
    if (mem_we) begin
      m_wr_addr <= mem_addr;
      m_wr_data <= mem_din;
    end
  end
  assign mem_dout = (mem_addr == 32'h100)   ? 32'hDEAD_BEEF :
                    (mem_addr == 32'h104)   ? 32'hCAFE_F00D :
                    (mem_addr == m_wr_addr) ? m_wr_data     : 32'h0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, " ack0"}, {31'd0, ack0}, 32'd0);
    check_val({tag, " ack1"}, {31'd0, ack1}, 32'd0);
    check_val({tag, " sel"}, {31'd0, sel}, 32'd0);
    check_val({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    check_val({tag, " mem_addr"}, mem_addr, 32'd0);
    check_val({tag, " mem_din"}, mem_din, 32'd0);
    check_val({tag, " rdata"}, rdata, 32'd0);
  endtask

  initial begin
    logic          exp_sel;
    logic [DW-1:0] exp_rd;
    rst = 1'b1;
    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0; wdata0 = 32'hAAAA_0000;
    req1 = 1'b1; addr1 = 32'h104; we1 = 1'b0; wdata1 = 32'hBBBB_0000;

    // reset with both requests pending
    tick(); check_idle_zero("rst1");
    tick(); check_idle_zero("rst2");
    rst = 1'b0;

    // contention: both held through four accesses
    for (int k = 0; k < 4; k++) begin
      exp_sel = FIXED ? 1'b1 : k[0];
      exp_rd  = exp_sel ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      tick();
      check_val($sformatf("cont%0d sel", k), {31'd0, sel}, {31'd0, exp_sel});
      check_val($sformatf("cont%0d busy", k), {31'd0, busy}, 32'd1);
      check_val($sformatf("cont%0d addr", k), mem_addr, exp_sel ? 32'h104 : 32'h100);
      tick();
      check_val($sformatf("cont%0d ack0 early", k), {31'd0, ack0}, 32'd0);
      check_val($sformatf("cont%0d ack1 early", k), {31'd0, ack1}, 32'd0);
      tick();
      check_val($sformatf("cont%0d ack0", k), {31'd0, ack0}, {31'd0, ~exp_sel});
      check_val($sformatf("cont%0d ack1", k), {31'd0, ack1}, {31'd0, exp_sel});
      check_val($sformatf("cont%0d rdata", k), rdata, exp_rd);
      tick();
      check_val($sformatf("cont%0d idle busy", k), {31'd0, busy}, 32'd0);
      check_val($sformatf("cont%0d idle acks", k), {30'd0, ack1, ack0}, 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check_val("quiet busy", {31'd0, busy}, 32'd0);

    // single read from requester 0
    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0;
    tick();
    check_val("rd sel", {31'd0, sel}, 32'd0);
    check_val("rd addr1", mem_addr, 32'h100);
    check_val("rd we1", {31'd0, mem_we}, 32'd0);
    tick();
    check_val("rd addr2", mem_addr, 32'h100);
    check_val("rd we2", {31'd0, mem_we}, 32'd0);
    check_val("rd noack", {31'd0, ack0}, 32'd0);
    tick();
    check_val("rd ack0", {31'd0, ack0}, 32'd1);
    check_val("rd ack1", {31'd0, ack1}, 32'd0);
    check_val("rd rdata", rdata, 32'hDEAD_BEEF);
    req0 = 1'b0;
    tick();
    check_val("rd idle ack0", {31'd0, ack0}, 32'd0);

    // write from requester 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    tick();
    check_val("wr sel", {31'd0, sel}, 32'd1);
    check_val("wr we1", {31'd0, mem_we}, 32'd1);
    check_val("wr din", mem_din, 32'h1234_5678);
    check_val("wr addr", mem_addr, 32'h20);
    tick();
    check_val("wr we2", {31'd0, mem_we}, 32'd0);
    check_val("wr din hold", mem_din, 32'h1234_5678);
    check_val("wr sel hold", {31'd0, sel}, 32'd1);
    tick();
    check_val("wr ack1", {31'd0, ack1}, 32'd1);
    check_val("wr ack0", {31'd0, ack0}, 32'd0);
    check_val("wr rdata kept", rdata, 32'hDEAD_BEEF);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check_val("wr idle sel", {31'd0, sel}, 32'd1);
    check_val("wr idle busy", {31'd0, busy}, 32'd0);

    // read back the written word; Req0 dropped mid-ACCESS
    req0 = 1'b1; addr0 = 32'h20;
    tick();
    check_val("rb sel", {31'd0, sel}, 32'd0);
    req0 = 1'b0;
    tick();
    tick();
    check_val("rb ack0", {31'd0, ack0}, 32'd1);
    check_val("rb rdata", rdata, 32'h1234_5678);
    tick();
    check_val("rb idle sel", {31'd0, sel}, 32'd0);

    // reset in the last ACCESS cycle of a read
    req0 = 1'b1; addr0 = 32'h100;
    tick();
    check_val("ra busy", {31'd0, busy}, 32'd1);
    tick();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b1; addr1 = 32'h104; we1 = 1'b0;
    tick();
    check_idle_zero("ra");
    rst = 1'b0;
    tick();
    check_val("ra r1 sel", {31'd0, sel}, 32'd1);
    check_val("ra r1 addr", mem_addr, 32'h104);
    tick();
    check_val("ra r1 noack", {30'd0, ack1, ack0}, 32'd0);
    tick();
    check_val("ra r1 ack1", {31'd0, ack1}, 32'd1);
    check_val("ra r1 ack0", {31'd0, ack0}, 32'd0);
    check_val("ra r1 rdata", rdata, 32'hCAFE_F00D);
    req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: requester 0 is instruction fetch and requester 1 is data load/store.
- Sequences each access through a fixed-latency memory.
- Drives the Sel line of the external 32-bit 2:1 muxes that steer the owner's address and write data into the memory.
- Returns per-requester completion pulses.
- Sits between the fetch/load-store units and the memory in the multicycle datapath.

Parameters:
- DATA_W, 32, width of data and address buses.
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15; 0 is illegal.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- Req0  in  1  request from requester 0 (fetch).
- Addr0  in  DATA_W  address from requester 0.
- We0  in  1  write enable from requester 0; 1 = write.
- Wdata0  in  DATA_W  write data from requester 0.
- Req1, Addr1, We1, Wdata1  in  1/DATA_W/1/DATA_W  same signals for requester 1 (data).
- Ack0  out  1  one-cycle completion pulse to requester 0.
- Ack1  out  1  one-cycle completion pulse to requester 1.
- Rdata  out  DATA_W  read data; valid in the Ack cycle.
- Sel  out  1  current owner; drives the Sel input of the external address/data muxes.
- Busy  out  1  high while in ACCESS or RESP.
- MemAddr  out  DATA_W  registered address to memory.
- MemWe  out  1  memory write strobe.
- MemDin  out  DATA_W  registered write data to memory.
- MemDout  in  DATA_W  memory read data; valid at the last ACCESS cycle.

Behaviour:
- Reset (Rst high at an edge):
  - State goes to IDLE.
  - Sel, Ack0, Ack1, MemWe, Busy, MemAddr, MemDin, Rdata and the latency counter all go to 0.
  - Internal Last (last-granted requester) goes to 1, so requester 0 wins the first tie.
  - Reset overrides everything, including mid-ACCESS and mid-RESP: no Ack is issued for the aborted access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, grant decision at cycle t:
  - No Req asserted: stay in IDLE.
  - One Req asserted: grant that requester.
  - Both asserted: grant the requester not equal to Last (round-robin).
  - On grant: Sel <= winner; Last <= winner; MemAddr/MemDin <= winner's Addr/Wdata; latch winner's We; counter <= MEM_LAT-1; go to ACCESS.
- ACCESS, cycles t+1 .. t+MEM_LAT:
  - MemAddr, MemDin and Sel are held stable.
  - MemWe is high in the first ACCESS cycle only, and only for writes.
  - Counter decrements each cycle.
  - At counter==0: reads capture MemDout into Rdata, then go to RESP.
- RESP, cycle t+MEM_LAT+1:
  - Ack of Sel's requester is high for exactly one cycle; the other Ack stays 0.
  - Rdata is valid (reads).
  - Next state is IDLE.
- Latency: request sampled at t produces Ack at t+MEM_LAT+1. Back-to-back grants are spaced MEM_LAT+2 cycles apart.
- Rdata is updated only by reads and holds its value across writes.
- Requester rules:
  - Hold Req, Addr, We and Wdata stable from assertion until Ack.
  - Req is ignored in ACCESS and RESP.
  - Req still high in the cycle after Ack is treated as a new request.
- Req dropped mid-ACCESS: the access completes and Ack is still issued.
- Sel holds the last owner while in IDLE.
- Busy is 0 in IDLE and 1 in ACCESS and RESP.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 1 (data) always wins ties and Last is not used. Requester 0 can starve while Req1 is continuously reasserted.
- Undefined: round-robin tie-break as specified in Behaviour.

Test Plan (MEM_LAT=2):
- Reset: Rst high for 2 cycles with Req0=Req1=1 -> all outputs 0, no Ack during reset; first grant after reset goes to requester 0 (Sel=0).
- Single read: Req0=1, Addr0=0x00000100 at t; memory model returns 0xDEADBEEF -> MemAddr=0x100 and MemWe=0 at t+1..t+2; Ack0=1 with Rdata=0xDEADBEEF at t+3; Ack1 stays 0.
- Write: Req1=1, We1=1, Addr1=0x20, Wdata1=0x12345678 at t -> Sel=1 from t+1; MemWe=1 at t+1 only with MemDin=0x12345678; Ack1 at t+3; Rdata unchanged.
- Contention: Req0 and Req1 held continuously (each reasserted after Ack) -> grant order 0,1,0,1; Sel toggles per access; Acks spaced 4 cycles apart; never both Acks in the same cycle.
- Reset mid-ACCESS: Rst at t+2 of a read -> IDLE on the next cycle, no Ack, MemWe=0, Last=1; a held Req1 alone is then granted normally.
- ARB_FIXED_PRIO_EN defined, both Req held -> requester 1 granted on every arbitration; requester 0 is granted only after Req1 drops.
